mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
Round-robin arbiter that shares the 4:1 single-bit select mux between four requesters (pixel/serial sources).
- Grants one requester at a time and drives the mux select to the granted input.
- Enforces a maximum burst length so no source starves the others.
- Sits directly in front of the mux select port; the grant vector goes back to the requesters.

Parameters:
MAX_BURST, 16, max consecutive granted cycles per owner while others wait (legal range 2..256)
CNT_W, $clog2(MAX_BURST), burst counter width (derived, not overridden)

Ports:
clk    input   1  system clock, all state on rising edge
rst_n  input   1  asynchronous active-low reset
req    input   4  request vector, bit i = requester i wants the mux
grant  output  4  one-hot grant, registered; all-zero when idle
sel    output  2  mux select, registered; index of current/last owner
busy   output  1  registered; 1 while any grant is active

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): grant=0, sel=2'b00, busy=0, burst_cnt=0, last_ptr=3, state=IDLE. Requester 0 therefore wins first.
- Reset mid-grant: outputs drop to reset values immediately; no completion of the burst.
- States: IDLE, GRANT.
- Pick function: first set bit of a candidate mask, scanning circularly from last_ptr+1 upward (mod 4).
- IDLE, req=0: stay in IDLE; grant=0, busy=0, sel holds its last value (no select toggling while idle).
- IDLE, req!=0: next cycle grant=onehot(pick(req)), sel=pick, busy=1, burst_cnt=0, last_ptr=pick, go to GRANT. Latency from req to grant is 1 cycle.
- GRANT, req[sel]=1 and burst_cnt<MAX_BURST-1: hold; burst_cnt++.
- GRANT, req[sel]=0 (release):
  - other req pending -> next cycle grant the pick over req with bit sel masked; no idle gap.
  - else -> IDLE with grant=0, busy=0.
- GRANT, burst_cnt==MAX_BURST-1 and req[sel]=1 (expiry):
  - other req pending -> rotate to the pick over the masked req; burst_cnt=0.
  - no other req -> keep owner, burst_cnt=0 (no forced gap).
- Release and expiry in the same cycle: treated as release.
- Every grant change updates sel and last_ptr in the same cycle.
- Invariants: grant is always one-hot or zero; grant!=0 implies grant[sel]=1; busy equals |grant.
- burst_cnt saturates logically at MAX_BURST-1; it never wraps while the owner holds.

Optional Feature:
MUX_SEL_ARBITER_LOCK_EN
- Defined: adds input port lock (1 bit). While lock=1 and req[sel]=1 in GRANT, the burst limit is ignored and burst_cnt holds. Releasing lock with burst_cnt already at MAX_BURST-1 triggers the expiry rule on that cycle.
- Undefined: port absent; the burst limit is always enforced.

Decomposition:
Shared package mux_arb_pkg holds:
- state enum (IDLE=1'b0, GRANT=1'b1)
- NUM_REQ=4 and SEL_W=2 constants
- function onehot2idx

Sub-module rr_pick (purely combinational):
- inputs: 4-bit mask, 2-bit last_ptr
- outputs: 2-bit idx, 1-bit found
- instantiated once; the masked-vs-unmasked candidate selection stays in the parent.

Test Plan:
- Reset then req=4'b1111 held -> grant 0001 one cycle after req, then 0010, 0100, 1000, 0001, rotating every 16 cycles (MAX_BURST=16); sel follows 0,1,2,3.
- req=4'b0100 alone for 40 cycles -> grant=0100 continuously, sel=2, busy=1, no gap at cycles 16/32.
- Owner 1 drops req at cycle 5 while req[3]=1 -> next cycle grant=1000, sel=3, no zero-grant cycle.
- All req drop -> next cycle grant=0, busy=0, sel stays at last owner value.
- Owner 2 drops req on exactly its 16th cycle with req[0]=1 -> release path; grant=0001 next cycle, burst_cnt=0.
- rst_n pulsed low mid-burst with grant=0010 -> grant=0, sel=0, busy=0 asynchronously; after release, req=4'b1010 -> grant=0010 first (last_ptr=3 wraps to 0, and req[0]=0).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the mux select arbiter: FSM state encoding,
// requester count / select width, and one-hot <-> index conversions.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index of the set bit in a one-hot vector (0 when the vector is zero).
    function automatic logic [SEL_W-1:0] onehot2idx(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    // One-hot vector with bit idx set.
    function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first set bit of
// mask scanning circularly upward from last_ptr+1; found=0 when mask is zero.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] mask,
    input  logic [SEL_W-1:0]   last_ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    // rot[k] is the candidate k+1 positions after last_ptr, so rot[0] has
    // highest priority and last_ptr itself is examined last.
    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   off;

    genvar k;
    generate
        for (k = 0; k < NUM_REQ; k++) begin : g_rot
            assign rot[k] = mask[SEL_W'(last_ptr + SEL_W'(k + 1))];
        end
    endgenerate

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = SEL_W'(i);
            end
        end
    end

    assign idx = SEL_W'(last_ptr + off + SEL_W'(1));

endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter driving the select of a 4:1 mux.
// One owner at a time, bounded burst length, no idle gap on hand-over.
// Optional macro MUX_SEL_ARBITER_LOCK_EN adds a 'lock' input that suspends
// the burst limit while the current owner keeps requesting.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int MAX_BURST = 16,
    localparam int CNT_W     = $clog2(MAX_BURST)
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef MUX_SEL_ARBITER_LOCK_EN
    input  logic               lock,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic               busy_nxt;
    logic [CNT_W-1:0]   burst_cnt, cnt_nxt;
    logic [SEL_W-1:0]   last_ptr, last_nxt;

    logic [NUM_REQ-1:0] cand;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;
    logic [SEL_W-1:0]   own_idx;
    logic               lock_on;

`ifdef MUX_SEL_ARBITER_LOCK_EN
    assign lock_on = lock;
`else
    assign lock_on = 1'b0;
`endif

    // While granted, the owner is masked out so release/expiry only ever
    // hands over to somebody else; from IDLE every requester is a candidate.
    assign own_idx = onehot2idx(grant);
    assign cand    = (state == GRANT) ? (req & ~grant) : req;

    rr_pick u_pick (
        .mask     (cand),
        .last_ptr (last_ptr),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    // Next-state / next-output logic.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = sel;
        last_nxt  = last_ptr;
        cnt_nxt   = burst_cnt;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = GRANT;
                    grant_nxt = idx2onehot(pick_idx);
                    sel_nxt   = pick_idx;
                    last_nxt  = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!req[own_idx]) begin
                    // Release (takes precedence over a coincident expiry).
                    cnt_nxt = '0;
                    if (pick_found) begin
                        grant_nxt = idx2onehot(pick_idx);
                        sel_nxt   = pick_idx;
                        last_nxt  = pick_idx;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end else if (lock_on) begin
                    // Locked owner: burst limit suspended, counter frozen.
                    cnt_nxt = burst_cnt;
                end else if (burst_cnt != CNT_MAX) begin
                    cnt_nxt = burst_cnt + CNT_W'(1);
                end else begin
                    // Expiry: rotate if anyone else waits, else keep owner.
                    cnt_nxt = '0;
                    if (pick_found) begin
                        grant_nxt = idx2onehot(pick_idx);
                        sel_nxt   = pick_idx;
                        last_nxt  = pick_idx;
                    end
                end
            end
        endcase
        busy_nxt = |grant_nxt;
    end

    // State and registered outputs; reset forces requester 0 to win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            sel       <= '0;
            busy      <= 1'b0;
            burst_cnt <= '0;
            last_ptr  <= SEL_W'(NUM_REQ - 1);
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            sel       <= sel_nxt;
            busy      <= busy_nxt;
            burst_cnt <= cnt_nxt;
            last_ptr  <= last_nxt;
        end
    end

    // Structural invariants of the grant outputs.
    a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_selown : assert property (@(posedge clk) disable iff (!rst_n) (grant != '0) |-> grant[sel]);
    a_busy   : assert property (@(posedge clk) disable iff (!rst_n) busy == (|grant));

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed testbench for mux_sel_arbiter (MAX_BURST=16). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
`ifdef MUX_SEL_ARBITER_LOCK_EN
    logic       lock = 1'b0;
`endif

    int vecs = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.MAX_BURST(16)) dut (
`ifdef MUX_SEL_ARBITER_LOCK_EN
        .lock  (lock),
`endif
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant),
        .sel   (sel),
        .busy  (busy)
    );

    // Compare packed {busy, sel, grant} against the hand-computed value.
    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got busy/sel/grant=%b/%b/%b, exp %b/%b/%b",
                     tag, got[6], got[5:4], got[3:0], exp[6], exp[5:4], exp[3:0]);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic b);
        chk(tag, {busy, sel, grant}, {b, s, g});
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        expect_out("reset", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        expect_out("idle_after_reset", 4'b0000, 2'd0, 1'b0);

        // All four requesting: 16-cycle bursts rotating 0,1,2,3,0,1.
        req = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (c == 0 || c == 15)
                    expect_out($sformatf("rr_o%0d_c%0d", o, c), 4'b0001 << (o % 4),
                               2'(o % 4), 1'b1);
            end
        end
        @(negedge clk);
        expect_out("rr_wrap_to_1", 4'b0010, 2'd1, 1'b1);

        // Everyone drops: idle next cycle, sel holds last owner.
        req = 4'b0000;
        @(negedge clk);
        expect_out("all_drop", 4'b0000, 2'd1, 1'b0);

        // Lone requester 2 for 40 cycles: no gap at the burst boundaries.
        req = 4'b0100;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            expect_out($sformatf("solo2_c%0d", c), 4'b0100, 2'd2, 1'b1);
        end
        req = 4'b0000;
        @(negedge clk);
        expect_out("solo2_drop", 4'b0000, 2'd2, 1'b0);

        // Owner 1 releases at cycle 5 with requester 3 waiting.
        req = 4'b0010;
        @(negedge clk);
        expect_out("own1_c1", 4'b0010, 2'd1, 1'b1);
        req = 4'b1010;
        repeat (4) @(negedge clk);
        expect_out("own1_c5", 4'b0010, 2'd1, 1'b1);
        req = 4'b1000;
        @(negedge clk);
        expect_out("release_to_3", 4'b1000, 2'd3, 1'b1);
        req = 4'b0000;
        @(negedge clk);
        expect_out("idle_sel3", 4'b0000, 2'd3, 1'b0);

        // Owner 2 releases on exactly its 16th cycle with requester 0 pending.
        req = 4'b0100;
        @(negedge clk);
        expect_out("own2_c1", 4'b0100, 2'd2, 1'b1);
        req = 4'b0101;
        repeat (15) @(negedge clk);
        expect_out("own2_c16", 4'b0100, 2'd2, 1'b1);
        req = 4'b0011;
        @(negedge clk);
        expect_out("release_at_limit", 4'b0001, 2'd0, 1'b1);
        // Fresh counter: owner 0 keeps a full 16 cycles, then rotates to 1.
        repeat (15) @(negedge clk);
        expect_out("own0_c16", 4'b0001, 2'd0, 1'b1);
        @(negedge clk);
        expect_out("own0_expire_to_1", 4'b0010, 2'd1, 1'b1);

        // Asynchronous reset in the middle of owner 1's burst.
        repeat (3) @(negedge clk);
        expect_out("own1_mid", 4'b0010, 2'd1, 1'b1);
        #2 rst_n = 1'b0;
        #1 expect_out("async_reset", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1010;
        @(negedge clk);
        expect_out("post_reset_first", 4'b0010, 2'd1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
